// File: rtl/riscv_trace_buffer_pkg.sv
// Shared definitions for the retirement-trace monitor: default field widths,
// the halting instruction encodings and the monitor FSM state encoding.
package riscv_trace_buffer_pkg;

   localparam int ADDR_SIZE_DEF  = 32;
   localparam int INSTR_SIZE_DEF = 32;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } trace_state_t;

endpackage

// File: rtl/riscv_trace_buffer_trace_ring.sv
// Parametrised WIDTH x DEPTH ring buffer with show-ahead read port.
// When full, a push without a pop is either dropped (OVERWRITE=0) or replaces
// the oldest entry (OVERWRITE=1). A pop on an empty buffer is ignored.
module trace_ring #(
   parameter int WIDTH     = 64,
   parameter int DEPTH     = 16,
   parameter int OVERWRITE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             pop_eff;
   logic             push_wr;
   logic             ovw;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign pop_eff = pop && !empty;
   // full with no pop: either the oldest entry is displaced or the push is lost
   assign ovw     = push && full && !pop_eff && (OVERWRITE != 0);
   assign push_wr = push && (!full || pop_eff || (OVERWRITE != 0));

   assign dout  = empty ? '0 : mem[rd_ptr];
   assign count = cnt;

   // pointer and occupancy update; pointers wrap naturally since DEPTH is 2^PW
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_wr)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop_eff || ovw)
            rd_ptr <= rd_ptr + PW'(1);
         if (push_wr && !(pop_eff || ovw))
            cnt <= cnt + CW'(1);
         else if (pop_eff && !push_wr)
            cnt <= cnt - CW'(1);
      end
   end

   // entry storage; contents outside the valid window are don't-care
   always_ff @(posedge clk) begin
      if (push_wr)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/riscv_trace_buffer.sv
// Retirement-trace monitor: records retired (pc, instr[, cycle]) entries in a
// ring buffer, keeps cycle/retire/drop counters and detects program halt.
// Optional build macro TRACE_CYCLE_STAMP_EN adds a per-entry cycle stamp
// driven on out_cycle; without it out_cycle is tied to zero.
//
// state | meaning
// IDLE  | waiting for the first retire; nothing counted
// RUN   | recording retires, counting cycles, watching for halt
// HALT  | ecall/ebreak retired or retire stream went quiet; retires ignored
module riscv_trace_buffer
   import riscv_trace_buffer_pkg::*;
#(
   parameter int ADDR_SIZE   = ADDR_SIZE_DEF,
   parameter int INSTR_SIZE  = INSTR_SIZE_DEF,
   parameter int DEPTH       = 16,
   parameter int CNT_W       = 32,
   parameter int HALT_CYCLES = 8,
   parameter int OVERWRITE   = 0
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    clr,
   input  logic                    valid_w,
   input  logic [ADDR_SIZE-1:0]    pc_w,
   input  logic [INSTR_SIZE-1:0]   instr_w,
   input  logic                    pop,
   output logic                    out_valid,
   output logic [ADDR_SIZE-1:0]    out_pc,
   output logic [INSTR_SIZE-1:0]   out_instr,
   output logic [CNT_W-1:0]        out_cycle,
   output logic [$clog2(DEPTH):0]  count,
   output logic [CNT_W-1:0]        cycle_cnt,
   output logic [CNT_W-1:0]        retire_cnt,
   output logic [CNT_W-1:0]        drop_cnt,
   output logic                    halted
);

   localparam int IDW = $clog2(HALT_CYCLES + 1);
   localparam logic [INSTR_SIZE-1:0] ECALL_W  = INSTR_SIZE'(INSTR_ECALL);
   localparam logic [INSTR_SIZE-1:0] EBREAK_W = INSTR_SIZE'(INSTR_EBREAK);

`ifdef TRACE_CYCLE_STAMP_EN
   localparam int EW = CNT_W + ADDR_SIZE + INSTR_SIZE;
`else
   localparam int EW = ADDR_SIZE + INSTR_SIZE;
`endif

   trace_state_t   state;
   trace_state_t   state_nxt;
   logic [IDW-1:0] idle_cnt;
   logic [IDW-1:0] idle_nxt;
   logic           accept;
   logic           run_tick;
   logic           halt_instr;
   logic           ring_full;
   logic           ring_empty;
   logic           lost;
   logic [EW-1:0]  push_data;
   logic [EW-1:0]  head;

   assign halt_instr = (instr_w == ECALL_W) || (instr_w == EBREAK_W);

   // state register
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn)
         state <= ST_IDLE;
      else if (clr)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // next state, retire acceptance and idle tracking
   always_comb begin
      state_nxt = state;
      idle_nxt  = idle_cnt;
      accept    = 1'b0;
      run_tick  = 1'b0;
      case (state)
         ST_IDLE: begin
            // the entering cycle is counted so the first retire is stamped 0
            // and the next cycle's retire is stamped 1
            if (valid_w) begin
               accept    = 1'b1;
               run_tick  = 1'b1;
               idle_nxt  = '0;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            run_tick = 1'b1;
            if (valid_w) begin
               accept   = 1'b1;
               idle_nxt = '0;
               if (halt_instr)
                  state_nxt = ST_HALT;
            end else begin
               idle_nxt = idle_cnt + IDW'(1);
               if (idle_cnt == IDW'(HALT_CYCLES - 1))
                  state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            state_nxt = ST_HALT;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // a push is lost (dropped or displacing the oldest) only when full and not popping
   assign lost = accept && ring_full && !(pop && !ring_empty);

   // saturating counters and the idle-run tracker
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         idle_cnt   <= '0;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         drop_cnt   <= '0;
      end else if (clr) begin
         idle_cnt   <= '0;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         drop_cnt   <= '0;
      end else begin
         idle_cnt <= idle_nxt;
         if (run_tick && (cycle_cnt != '1))
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (accept && (retire_cnt != '1))
            retire_cnt <= retire_cnt + CNT_W'(1);
         if (lost && (drop_cnt != '1))
            drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

`ifdef TRACE_CYCLE_STAMP_EN
   assign push_data = {cycle_cnt, pc_w, instr_w};
   assign out_cycle = head[EW-1 -: CNT_W];
`else
   assign push_data = {pc_w, instr_w};
   assign out_cycle = '0;
`endif

   assign out_pc    = head[INSTR_SIZE +: ADDR_SIZE];
   assign out_instr = head[INSTR_SIZE-1:0];
   assign out_valid = !ring_empty;
   assign halted    = (state == ST_HALT);

   trace_ring #(
      .WIDTH     (EW),
      .DEPTH     (DEPTH),
      .OVERWRITE (OVERWRITE)
   ) u_ring (
      .clk   (clk),
      .rst   (rstn),
      .clr   (clr),
      .push  (accept),
      .pop   (pop),
      .din   (push_data),
      .dout  (head),
      .count (count),
      .full  (ring_full),
      .empty (ring_empty)
   );

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer: two instances (drop and overwrite policy,
// DEPTH=4) share one directed stimulus stream and are compared every cycle
// against a queue-based model, plus literal expectations for the plan cases.
module tb_riscv_trace_buffer;

   localparam int DEPTH = 4;
   localparam int HC    = 8;
   localparam int NW    = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [31:0] EBRK  = 32'h0010_0073;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] stamp;
   } entry_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        clr = 1'b0;
   logic        valid_w = 1'b0;
   logic [31:0] pc_w = '0;
   logic [31:0] instr_w = '0;
   logic        pop = 1'b0;

   logic          a_valid, b_valid, a_halted, b_halted;
   logic [31:0]   a_pc, b_pc, a_instr, b_instr, a_stamp, b_stamp;
   logic [31:0]   a_cyc, b_cyc, a_ret, b_ret, a_drop, b_drop;
   logic [NW-1:0] a_count, b_count;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   riscv_trace_buffer #(.ADDR_SIZE(32), .INSTR_SIZE(32), .DEPTH(DEPTH), .CNT_W(32),
                        .HALT_CYCLES(HC), .OVERWRITE(0)) dut_a (
      .clk(clk), .rstn(rstn), .clr(clr), .valid_w(valid_w), .pc_w(pc_w),
      .instr_w(instr_w), .pop(pop), .out_valid(a_valid), .out_pc(a_pc),
      .out_instr(a_instr), .out_cycle(a_stamp), .count(a_count),
      .cycle_cnt(a_cyc), .retire_cnt(a_ret), .drop_cnt(a_drop), .halted(a_halted));

   riscv_trace_buffer #(.ADDR_SIZE(32), .INSTR_SIZE(32), .DEPTH(DEPTH), .CNT_W(32),
                        .HALT_CYCLES(HC), .OVERWRITE(1)) dut_b (
      .clk(clk), .rstn(rstn), .clr(clr), .valid_w(valid_w), .pc_w(pc_w),
      .instr_w(instr_w), .pop(pop), .out_valid(b_valid), .out_pc(b_pc),
      .out_instr(b_instr), .out_cycle(b_stamp), .count(b_count),
      .cycle_cnt(b_cyc), .retire_cnt(b_ret), .drop_cnt(b_drop), .halted(b_halted));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   entry_t      q0[$];
   entry_t      q1[$];
   bit          m_started, m_halted;
   logic [31:0] m_cyc, m_ret, m_drop;
   int          m_idle;

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      m_started = 0;
      m_halted  = 0;
      m_cyc     = '0;
      m_ret     = '0;
      m_drop    = '0;
      m_idle    = 0;
   endtask

   task automatic model_step();
      bit     in_run, acc, pop_e, was_full;
      entry_t e;
      in_run   = m_started && !m_halted;
      acc      = valid_w && !m_halted;
      pop_e    = pop && (q0.size() > 0);
      was_full = (q0.size() == DEPTH);
      e.pc     = pc_w;
      e.instr  = instr_w;
      e.stamp  = m_cyc;
      if (pop_e) begin
         void'(q0.pop_front());
         void'(q1.pop_front());
      end
      if (acc) begin
         if (was_full && !pop_e) begin
            m_drop = sat(m_drop);
            void'(q1.pop_front());
            q1.push_back(e);
         end else begin
            q0.push_back(e);
            q1.push_back(e);
         end
         m_ret = sat(m_ret);
      end
      if (acc || in_run)
         m_cyc = sat(m_cyc);
      if (in_run) begin
         if (valid_w) begin
            m_idle = 0;
            if (instr_w == ECALL || instr_w == EBRK)
               m_halted = 1;
         end else begin
            m_idle++;
            if (m_idle == HC)
               m_halted = 1;
         end
      end else if (!m_halted && valid_w) begin
         m_started = 1;
      end
   endtask

   always @(posedge clk or posedge rstn) begin
      if (rstn || clr)
         model_reset();
      else
         model_step();
   end

   // per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (!rstn) begin
         chk("a_valid", a_valid, q0.size() > 0);
         chk("b_valid", b_valid, q1.size() > 0);
         chk("a_count", a_count, q0.size());
         chk("b_count", b_count, q1.size());
         if (q0.size() > 0) begin
            chk("a_pc", a_pc, q0[0].pc);
            chk("a_instr", a_instr, q0[0].instr);
`ifdef TRACE_CYCLE_STAMP_EN
            chk("a_stamp", a_stamp, q0[0].stamp);
`else
            chk("a_stamp", a_stamp, 0);
`endif
         end else begin
            chk("a_pc_empty", a_pc, 0);
            chk("a_instr_empty", a_instr, 0);
         end
         if (q1.size() > 0) begin
            chk("b_pc", b_pc, q1[0].pc);
            chk("b_instr", b_instr, q1[0].instr);
         end else begin
            chk("b_pc_empty", b_pc, 0);
         end
         chk("a_cycle_cnt", a_cyc, m_cyc);
         chk("b_cycle_cnt", b_cyc, m_cyc);
         chk("a_retire_cnt", a_ret, m_ret);
         chk("b_retire_cnt", b_ret, m_ret);
         chk("a_drop_cnt", a_drop, m_drop);
         chk("b_drop_cnt", b_drop, m_drop);
         chk("a_halted", a_halted, m_halted);
         chk("b_halted", b_halted, m_halted);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic v, input logic [31:0] p, input logic [31:0] ins,
                       input logic pp, input logic c);
      valid_w = v;
      pc_w    = p;
      instr_w = ins;
      pop     = pp;
      clr     = c;
      @(posedge clk);
      #1;
   endtask

   int stamps[4];

   initial begin
`ifdef TRACE_CYCLE_STAMP_EN
      stamps = '{0, 1, 3, 5};
`else
      stamps = '{0, 0, 0, 0};
`endif
      repeat (2) @(posedge clk);
      #1 rstn = 1'b0;

      // 1: reset asserted asynchronously mid-run
      for (int i = 0; i < 5; i++) step(1, 32'(i * 4), NOP, 0, 0);
      chk("t1_ret_before", a_ret, 5);
      #2 rstn = 1'b1;
      #1;
      chk("t1_valid", a_valid, 0);
      chk("t1_count", a_count, 0);
      chk("t1_pc", a_pc, 0);
      chk("t1_cyc", a_cyc, 0);
      chk("t1_ret", a_ret, 0);
      chk("t1_b_count", b_count, 0);
      @(posedge clk);
      #1 rstn = 1'b0;
      step(0, 0, 0, 0, 0);
      chk("t1_idle_cyc", a_cyc, 0);
      chk("t1_idle_halt", a_halted, 0);

      // 2/3: seven retires into a 4-deep buffer, no pop
      for (int i = 0; i < 7; i++) step(1, 32'(i * 4), NOP, 0, 0);
      chk("t2_count", a_count, 4);
      chk("t2_head", a_pc, 32'h00);
      chk("t2_drop", a_drop, 3);
      chk("t2_ret", a_ret, 7);
      chk("t3_count", b_count, 4);
      chk("t3_head", b_pc, 32'h0C);
      chk("t3_drop", b_drop, 3);
      for (int i = 0; i < 4; i++) begin
         chk("t3_pop_pc", b_pc, 32'(32'h0C + i * 4));
         chk("t2_pop_pc", a_pc, 32'(i * 4));
         step(0, 0, 0, 1, 0);
      end
      chk("t23_empty_a", a_valid, 0);
      chk("t23_empty_b", b_valid, 0);
      step(0, 0, 0, 0, 1);

      // 4: sparse retires then ecall
      step(1, 32'h0, NOP, 0, 0);
      step(1, 32'h4, NOP, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 32'h8, NOP, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 32'hC, ECALL, 0, 0);
      chk("t4_halted", a_halted, 1);
      chk("t4_count", a_count, 4);
      chk("t4_cyc", a_cyc, 6);
      step(1, 32'h10, NOP, 0, 0);
      step(1, 32'h14, NOP, 0, 0);
      chk("t4_ret_frozen", a_ret, 4);
      chk("t4_cyc_frozen", a_cyc, 6);
      chk("t4_count_frozen", a_count, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t4_stamp", a_stamp, 32'(stamps[i]));
         chk("t4_pc", a_pc, 32'(i * 4));
         step(0, 0, 0, 1, 0);
      end
      chk("t4_drained", a_count, 0);
      step(0, 0, 0, 0, 1);

      // 5: idle timeout
      step(1, 32'h40, NOP, 0, 0);
      for (int i = 1; i <= HC; i++) begin
         step(0, 0, 0, 0, 0);
         if (i == HC - 1) chk("t5_not_yet", a_halted, 0);
      end
      chk("t5_halted", a_halted, 1);
      chk("t5_cyc", a_cyc, 9);
      step(0, 0, 0, 0, 1);

      // 6: full buffer with simultaneous push and pop, then clr
      for (int i = 0; i < 4; i++) step(1, 32'(32'h100 + i * 4), NOP, 0, 0);
      chk("t6_head_before", a_pc, 32'h100);
      step(1, 32'h110, NOP, 1, 0);
      chk("t6_count_a", a_count, 4);
      chk("t6_count_b", b_count, 4);
      chk("t6_head_a", a_pc, 32'h104);
      chk("t6_head_b", b_pc, 32'h104);
      chk("t6_drop_a", a_drop, 0);
      chk("t6_drop_b", b_drop, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
      chk("t6_tail", a_pc, 32'h110);
      step(1, 32'h200, NOP, 0, 1);
      chk("t6_clr_valid", a_valid, 0);
      chk("t6_clr_count", a_count, 0);
      chk("t6_clr_ret", a_ret, 0);
      chk("t6_clr_cyc", a_cyc, 0);
      chk("t6_clr_drop", a_drop, 0);
      chk("t6_clr_halt", a_halted, 0);
      step(0, 0, 0, 0, 0);
      chk("t6_idle_cyc", a_cyc, 0);

      // ebreak halts as well
      step(1, 32'h300, EBRK, 0, 0);
      step(1, 32'h304, EBRK, 0, 0);
      chk("t7_ebreak_halt", a_halted, 1);
      chk("t7_count", a_count, 2);
      step(0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
